// File: rtl/s_chunk_packer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// s_chunk_packer_pkg : shared sizes, base codes and packer states
// Revision: 1.0
// ---------------------------------------------------------------------------
package s_chunk_packer_pkg;

  localparam int PE_ARRAY_SIZE     = 16;
  localparam int PE_ARRAY_SIZE_LOG = 4;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/s_chunk_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// s_chunk_reg : valid-tagged chunk + count register (slot write, seal, load)
// Revision: 1.0
// ---------------------------------------------------------------------------
module s_chunk_reg #(
  parameter int SLOTS  = 16,
  parameter int SLOT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [2*SLOTS-1:0] load_data,
  input  logic [SLOT_W:0]    load_cnt,
  input  logic               wr_en,
  input  logic [SLOT_W-1:0]  wr_slot,
  input  logic [1:0]         wr_base,
  input  logic               seal,
  input  logic [SLOT_W:0]    seal_cnt,
  output logic [2*SLOTS-1:0] data,
  output logic [SLOT_W:0]    cnt,
  output logic               valid
);

  // Clearing zeroes the data so a partial chunk always has empty upper slots.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      data  <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      cnt   <= load_cnt;
      valid <= 1'b1;
    end else begin
      if (wr_en) begin
        data[{wr_slot, 1'b0} +: 2] <= wr_base;
      end
      if (seal) begin
        cnt   <= seal_cnt;
        valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/s_chunk_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// s_chunk_packer : packs a 2-bit base stream into PE-array-sized chunks and
//                  answers chunk requests from a two-deep pack/hold buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
module s_chunk_packer #(
  parameter int PE_ARRAY_SIZE     = s_chunk_packer_pkg::PE_ARRAY_SIZE,
  parameter int PE_ARRAY_SIZE_LOG = s_chunk_packer_pkg::PE_ARRAY_SIZE_LOG
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [1:0]                   i_base,
  input  logic                         i_base_valid,
  input  logic                         i_base_last,
  output logic                         o_base_ready,
  input  logic                         i_request_s,
  output logic [PE_ARRAY_SIZE*2-1:0]   o_s,
  output logic [PE_ARRAY_SIZE_LOG:0]   o_s_valid,
  output logic                         o_s_ack,
  output logic                         o_busy
);
  import s_chunk_packer_pkg::*;

  localparam logic [PE_ARRAY_SIZE_LOG-1:0] LAST_SLOT = PE_ARRAY_SIZE_LOG'(PE_ARRAY_SIZE - 1);

  state_t                         state;
  logic                           pending;
  logic [PE_ARRAY_SIZE_LOG-1:0]   pack_ptr;

  logic [PE_ARRAY_SIZE*2-1:0]     pack_data;
  logic [PE_ARRAY_SIZE_LOG:0]     pack_cnt;
  logic                           pack_valid;
  logic [PE_ARRAY_SIZE*2-1:0]     hold_data;
  logic [PE_ARRAY_SIZE_LOG:0]     hold_cnt;
  logic                           hold_valid;

  logic                           base_ready;
  logic                           accept;
  logic                           seal;
  logic [PE_ARRAY_SIZE_LOG:0]     seal_cnt;
  logic                           req;
  logic                           serve;
  logic                           move;
  logic                           zero_resp;

  assign base_ready = (state == ST_LOAD) && !pack_valid;
  assign accept     = i_base_valid && base_ready;
  assign seal       = accept && ((pack_ptr == LAST_SLOT) || i_base_last);
  assign seal_cnt   = {1'b0, pack_ptr} + (PE_ARRAY_SIZE_LOG+1)'(1);
  assign req        = i_request_s || pending;
  assign serve      = req && hold_valid;
  // The pack stage moves forward whenever the hold stage is free or being emptied now.
  assign move       = pack_valid && (!hold_valid || serve);
  assign zero_resp  = req && !hold_valid &&
                      (((state == ST_DRAIN) && !pack_valid) || (state == ST_DONE));

  assign o_base_ready = base_ready;
  assign o_busy       = (state == ST_LOAD) || (state == ST_DRAIN);

  s_chunk_reg #(
    .SLOTS  (PE_ARRAY_SIZE),
    .SLOT_W (PE_ARRAY_SIZE_LOG)
  ) u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (i_start || move),
    .load      (1'b0),
    .load_data ('0),
    .load_cnt  ('0),
    .wr_en     (accept && !i_start),
    .wr_slot   (pack_ptr),
    .wr_base   (i_base),
    .seal      (seal && !i_start),
    .seal_cnt  (seal_cnt),
    .data      (pack_data),
    .cnt       (pack_cnt),
    .valid     (pack_valid)
  );

  s_chunk_reg #(
    .SLOTS  (PE_ARRAY_SIZE),
    .SLOT_W (PE_ARRAY_SIZE_LOG)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (i_start || (serve && !move)),
    .load      (move && !i_start),
    .load_data (pack_data),
    .load_cnt  (pack_cnt),
    .wr_en     (1'b0),
    .wr_slot   ('0),
    .wr_base   (2'b00),
    .seal      (1'b0),
    .seal_cnt  ('0),
    .data      (hold_data),
    .cnt       (hold_cnt),
    .valid     (hold_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pending   <= 1'b0;
      pack_ptr  <= '0;
      o_s       <= '0;
      o_s_valid <= '0;
      o_s_ack   <= 1'b0;
    end else if (i_start) begin
      state    <= ST_LOAD;
      pending  <= 1'b0;
      pack_ptr <= '0;
      o_s_ack  <= 1'b0;
    end else begin
      o_s_ack <= 1'b0;

      if (accept) begin
        pack_ptr <= seal ? '0 : pack_ptr + 1'b1;
        if (i_base_last) begin
          state <= ST_DRAIN;
        end
      end

      if (serve) begin
        o_s       <= hold_data;
        o_s_valid <= hold_cnt;
        o_s_ack   <= 1'b1;
        pending   <= 1'b0;
      end else if (zero_resp) begin
        o_s       <= '0;
        o_s_valid <= '0;
        o_s_ack   <= 1'b1;
        pending   <= 1'b0;
        state     <= ST_DONE;
      end else if (i_request_s &&
                   ((state == ST_LOAD) || ((state == ST_DRAIN) && pack_valid))) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_s_chunk_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_s_chunk_packer : directed bench with a chunk-queue reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_s_chunk_packer;
  import s_chunk_packer_pkg::*;

  localparam int N  = PE_ARRAY_SIZE;
  localparam int CW = PE_ARRAY_SIZE_LOG + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [1:0]    i_base = 2'b00;
  logic          i_base_valid = 1'b0;
  logic          i_base_last = 1'b0;
  logic          o_base_ready;
  logic          i_request_s = 1'b0;
  logic [2*N-1:0] o_s;
  logic [CW-1:0] o_s_valid;
  logic          o_s_ack;
  logic          o_busy;

  always #5 clk = ~clk;

  s_chunk_packer #(
    .PE_ARRAY_SIZE     (PE_ARRAY_SIZE),
    .PE_ARRAY_SIZE_LOG (PE_ARRAY_SIZE_LOG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_base       (i_base),
    .i_base_valid (i_base_valid),
    .i_base_last  (i_base_last),
    .o_base_ready (o_base_ready),
    .i_request_s  (i_request_s),
    .o_s          (o_s),
    .o_s_valid    (o_s_valid),
    .o_s_ack      (o_s_ack),
    .o_busy       (o_busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: completed-but-undelivered chunks in order, plus the sequence phase.
  typedef struct {
    logic [2*N-1:0] data;
    int             cnt;
  } chunk_t;

  chunk_t         exp_q[$];
  logic [2*N-1:0] cur_data = '0;
  int             cur_cnt = 0;
  int             mode = 0;   // 0 idle, 1 loading, 2 last base seen, 3 done
  bit             out_req = 0;
  int             wait_cnt = 0;
  int             cyc = 0;
  int             seal_cyc = 0;
  int             ack_cyc = 0;

  bit         s_rst = 0, s_start = 0, s_acc = 0, s_last = 0, s_req = 0;
  logic [1:0] s_base = 2'b00;

  always @(negedge clk) begin
    s_rst   = !rst_n;
    s_start = i_start;
    s_acc   = i_base_valid && o_base_ready;
    s_last  = i_base_last;
    s_base  = i_base;
    s_req   = i_request_s;
  end

  task automatic model_clear();
    exp_q.delete();
    cur_data = '0;
    cur_cnt  = 0;
    out_req  = 0;
    wait_cnt = 0;
  endtask

  always @(posedge clk) begin : compare_proc
    chunk_t c;
    bit     sealed;
    bit     exp_ready;
    bit     exp_busy;
    #1;
    cyc++;
    sealed = 0;
    if (s_rst) begin
      model_clear();
      mode = 0;
      checks++;
      if (o_s !== '0 || o_s_valid !== '0) begin
        errors++;
        $display("FAIL reset_outputs got o_s=%0h cnt=%0d want 0/0", o_s, o_s_valid);
      end
    end else if (s_start) begin
      model_clear();
      mode = 1;
    end else begin
      if (s_acc) begin
        cur_data[2*cur_cnt +: 2] = s_base;
        cur_cnt++;
        if (cur_cnt == N || s_last) begin
          c.data = cur_data;
          c.cnt  = cur_cnt;
          exp_q.push_back(c);
          cur_data = '0;
          cur_cnt  = 0;
          seal_cyc = cyc;
          sealed   = 1;
        end
        if (s_last) mode = 2;
      end
      if (s_req && mode != 0) out_req = 1;
    end

    if (o_s_ack) begin
      ack_cyc = cyc;
      wait_cnt = 0;
      checks++;
      if (!out_req) begin
        errors++;
        $display("FAIL spurious_ack got ack=1 want no ack (o_s_valid=%0d)", o_s_valid);
      end else if (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        if (o_s !== c.data || int'(o_s_valid) != c.cnt) begin
          errors++;
          $display("FAIL chunk_data got %0h/%0d want %0h/%0d", o_s, o_s_valid, c.data, c.cnt);
        end
      end else if (mode >= 2) begin
        mode = 3;
        if (o_s !== '0 || o_s_valid !== '0) begin
          errors++;
          $display("FAIL zero_resp got %0h/%0d want 0/0", o_s, o_s_valid);
        end
      end else begin
        errors++;
        $display("FAIL early_ack got ack=1 want no chunk ready yet");
      end
      out_req = 0;
    end else if (out_req && (exp_q.size() > 0 || mode >= 2)) begin
      wait_cnt++;
      if (wait_cnt > 2) begin
        checks++;
        errors++;
        $display("FAIL ack_latency got %0d cycles without ack want <=2", wait_cnt);
        out_req  = 0;
        wait_cnt = 0;
      end
    end

    exp_ready = (mode == 1) && (exp_q.size() < 2) && !sealed;
    exp_busy  = (mode == 1) || (mode == 2);
    checks++;
    if (o_base_ready !== exp_ready) begin
      errors++;
      $display("FAIL base_ready got %0b want %0b at cycle %0d", o_base_ready, exp_ready, cyc);
    end
    checks++;
    if (o_busy !== exp_busy) begin
      errors++;
      $display("FAIL busy got %0b want %0b at cycle %0d", o_busy, exp_busy, cyc);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [2:0]     bq[$];
  logic [2*N-1:0] got_s;
  int             got_cnt;
  int             acc;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic request();
    i_request_s = 1'b1;
    tick();
    i_request_s = 1'b0;
  endtask

  task automatic load_bases(input int n, input int off, input bit with_last);
    for (int k = 0; k < n; k++) begin
      bq.push_back({1'(with_last && (k == n - 1)), 2'((k + off) % 4)});
    end
  endtask

  task automatic feed(output int accepted);
    int idle;
    accepted = 0;
    idle = 0;
    while (bq.size() > 0 && idle < 6) begin
      i_base_valid = 1'b1;
      i_base       = bq[0][1:0];
      i_base_last  = bq[0][2];
      if (o_base_ready) begin
        tick();
        void'(bq.pop_front());
        accepted++;
        idle = 0;
      end else begin
        tick();
        idle++;
      end
    end
    i_base_valid = 1'b0;
    i_base_last  = 1'b0;
    bq.delete();
  endtask

  task automatic wait_ack(input int limit);
    int n;
    n = 0;
    while (!o_s_ack && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (!o_s_ack) begin
      errors++;
      $display("FAIL ack_timeout got no ack want ack within %0d cycles", limit);
      got_s = 'x;
      got_cnt = -1;
    end else begin
      got_s   = o_s;
      got_cnt = int'(o_s_valid);
    end
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_ready", 64'(o_base_ready), 64'd0);
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_cnt", 64'(o_s_valid), 64'd0);

    // 16 bases ACGT repeating, one full chunk then exhaustion
    pulse_start();
    chk("t1_busy_on", 64'(o_busy), 64'd1);
    load_bases(16, 0, 1);
    feed(acc);
    chk("t1_accepted", 64'(acc), 64'd16);
    request();
    wait_ack(4);
    chk("t1_data", 64'(got_s), 64'hE4E4E4E4);
    chk("t1_cnt", 64'(got_cnt), 64'd16);
    request();
    wait_ack(4);
    chk("t1_zero_cnt", 64'(got_cnt), 64'd0);
    chk("t1_busy_off", 64'(o_busy), 64'd0);

    // 20 bases: full chunk, partial chunk, exhaustion
    pulse_start();
    load_bases(20, 0, 1);
    feed(acc);
    chk("t2_accepted", 64'(acc), 64'd20);
    request();
    wait_ack(4);
    chk("t2_cnt0", 64'(got_cnt), 64'd16);
    request();
    wait_ack(4);
    chk("t2_cnt1", 64'(got_cnt), 64'd4);
    chk("t2_partial_data", 64'(got_s), 64'h000000E4);
    request();
    wait_ack(4);
    chk("t2_cnt2", 64'(got_cnt), 64'd0);

    // request before any base: ack two edges after the completing edge
    pulse_start();
    request();
    load_bases(16, 0, 0);
    feed(acc);
    wait_ack(6);
    chk("t3_cnt", 64'(got_cnt), 64'd16);
    chk("t3_latency", 64'(ack_cyc - seal_cyc), 64'd2);
    load_bases(64, 2, 0);
    feed(acc);
    chk("t3_more_accepted", 64'(acc), 64'd32);
    chk("t3_ready_low", 64'(o_base_ready), 64'd0);

    // 40 bases without requests, then resume
    pulse_start();
    load_bases(40, 1, 1);
    feed(acc);
    chk("t4_stall_accepted", 64'(acc), 64'd32);
    chk("t4_ready_low", 64'(o_base_ready), 64'd0);
    request();
    chk("t4_resume", 64'(o_base_ready), 64'd1);
    wait_ack(2);
    chk("t4_data0", 64'(got_s), 64'h39393939);
    chk("t4_cnt0", 64'(got_cnt), 64'd16);
    load_bases(8, 1, 1);
    bq[7][2] = 1'b1;
    feed(acc);
    chk("t4_tail_accepted", 64'(acc), 64'd8);
    request();
    wait_ack(4);
    chk("t4_cnt1", 64'(got_cnt), 64'd16);
    request();
    wait_ack(4);
    chk("t4_cnt2", 64'(got_cnt), 64'd8);
    request();
    wait_ack(4);
    chk("t4_cnt3", 64'(got_cnt), 64'd0);

    // restart while draining with hold full
    pulse_start();
    load_bases(20, 0, 1);
    feed(acc);
    pulse_start();
    chk("t5_no_stale_ack", 64'(o_s_ack), 64'd0);
    bq.push_back({1'b0, BASE_T});
    bq.push_back({1'b0, BASE_T});
    bq.push_back({1'b1, BASE_C});
    feed(acc);
    request();
    wait_ack(4);
    chk("t5_cnt", 64'(got_cnt), 64'd3);
    chk("t5_data", 64'(got_s), 64'h0000001F);

    // reset mid-load after a delivered chunk
    pulse_start();
    load_bases(21, 3, 0);
    feed(acc);
    request();
    wait_ack(4);
    chk("t6_pre_cnt", 64'(got_cnt), 64'd16);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_s", 64'(o_s), 64'd0);
    chk("t6_cnt", 64'(o_s_valid), 64'd0);
    chk("t6_ack", 64'(o_s_ack), 64'd0);
    chk("t6_busy", 64'(o_busy), 64'd0);
    repeat (3) tick();
    chk("t6_ready_idle", 64'(o_base_ready), 64'd0);
    pulse_start();
    chk("t6_ready_after_start", 64'(o_base_ready), 64'd1);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/s_chunk_packer.md
Name: s_chunk_packer

Overview:
- Upstream feeder of the data-processing stage; supplies query sequence S in PE-array-sized chunks.
- Accepts S one 2-bit base per cycle over a valid/ready stream and packs bases into PE_ARRAY_SIZE-base words.
- Answers the data-processing stage's S request pulse with a packed chunk plus a valid-base count.
- Two-deep buffering (pack register + hold register) overlaps loading with consumption.

Parameters:
PE_ARRAY_SIZE, 16, bases per chunk (PE count)
PE_ARRAY_SIZE_LOG, 4, log2(PE_ARRAY_SIZE)

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  reset, synchronous, active-low
i_start  input  1  1-cycle pulse: begin new S; discards all buffered data
i_base  input  2  base code (A=0,C=1,G=2,T=3)
i_base_valid  input  1  i_base valid
i_base_last  input  1  qualifies i_base as final base of S
o_base_ready  output  1  packer accepts base this cycle
i_request_s  input  1  1-cycle request for next chunk
o_s  output  PE_ARRAY_SIZE*2  packed chunk; base k at bits [2k+1:2k]
o_s_valid  output  PE_ARRAY_SIZE_LOG+1  bases valid in o_s; 0 = S exhausted
o_s_ack  output  1  1-cycle pulse: o_s/o_s_valid freshly updated
o_busy  output  1  sequence loaded and not yet fully delivered

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; pack/hold registers, counts, flags, pending cleared; all outputs 0.
- States: IDLE -> (i_start) LOAD -> (last base accepted) DRAIN -> (zero-count response sent) DONE -> (i_start) LOAD. i_start in any state -> LOAD with everything cleared, pending request cancelled.
- o_base_ready = (state==LOAD) && !pack_full. Accept = i_base_valid && o_base_ready.
- Packing: on accept, base written at slot pack_cnt; pack_cnt++. On accept with pack_cnt==PE_ARRAY_SIZE-1 or i_base_last: pack_full=1, chunk count = pack_cnt+1, pack_cnt=0. Unwritten slots of a partial chunk are 0.
- Accept with i_base_last: state -> DRAIN after the edge; o_base_ready low from then on.
- Pack->hold: at edge where pack_full && (!hold_valid || hold served at this edge): hold <= pack, hold_valid=1, pack_full=0; the pack register is zeroed.
- Request service: a request (i_request_s, or pending flag) at an edge where hold_valid=1: o_s <= hold data, o_s_valid <= hold count, o_s_ack=1 next cycle, hold_valid cleared (unless refilled same edge).
- Request with hold empty, in LOAD or in DRAIN with pack_full: pending=1; served at first edge with hold_valid=1.
- Request in DRAIN with hold empty and pack empty: o_s <= 0, o_s_valid <= 0, ack; state -> DONE.
- Request while pending or in IDLE/DONE: in IDLE ignored; in DONE answered with zero count + ack; while pending, merged (no second response).
- o_s/o_s_valid hold value between acks.
- Latency: hold full -> ack 1 cycle after request. Request pending, chunk completes at edge E0: hold at E1, ack asserted after E2.
- o_busy = 1 in LOAD/DRAIN, 0 in IDLE/DONE.
- Zero-length S unsupported; i_base_last always accompanies a real base.
- i_base_valid ignored when o_base_ready=0; upstream holds data until accepted.

Decomposition:
- Shared package/include: PE_Array_size, PE_Array_size_log, base encodings, state localparams.
- One sub-module, s_chunk_reg: a valid-tagged chunk+count register with load/clear. Instantiated twice, for the pack and hold stages.

Test Plan:
- Start, 16 bases 0,1,2,3 repeating with last on 16th, then request -> ack; o_s=0xE4E4E4E4, o_s_valid=16; next request -> o_s_valid=0, o_busy falls.
- 20 bases, request after each ack -> counts 16, 4, 0. Second o_s: low 8 bits data, upper 24 bits zero.
- Request before any base, then feed 16 bases -> ready drops after the 32nd accepted base while no further request. Ack exactly 2 edges after the chunk-completing edge.
- 40 bases with no requests -> o_base_ready low after 32 accepted. A request resumes acceptance next cycle, and remaining chunks arrive in order.
- i_start mid-DRAIN with hold full, then new 3-base S and request -> o_s_valid=3 with new data only; no stale ack.
- rst_n low for 1 edge mid-LOAD -> all outputs 0, o_base_ready=0 until i_start.
